bmem_line_adapter: RTL and testbench

- Sits directly downstream of the cache arbiter and upstream of the burst memory model.
- Converts one 256-bit line request (read pulse or write pulse) into a 4-beat, 64-bit burst-memory transaction.
- Reads: reassembles the four returned beats into a line and pulses line_rvalid, which drives the arbiter's cache_valid.
- Writes: serialises the line onto the memory port and pulses line_wdone, which drives the arbiter's d_cache_valid.

---
 rtl/bmem_pkg.sv | 32 +++
 rtl/bmem_line_adapter_if.sv | 24 ++
 rtl/line_req_slot.sv | 27 ++
 rtl/bmem_line_adapter.sv | 115 +++++++++++
 tb/tb_bmem_line_adapter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmem_pkg.sv
// Shared constants and types for the burst-memory line adapter.
// Line is BEATS x BEAT_W; addresses are line-aligned on OFFSET_BITS.
package bmem_pkg;
  localparam int BEAT_W = 64;
  localparam int BEATS = 4;
  localparam int LINE_W = BEAT_W * BEATS;
  localparam int ADDR_W = 32;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_COLLECT,
    WR_BURST,
    RESP
  } adapter_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              is_write;
    logic [LINE_W-1:0] wdata;
  } line_req_t;

  localparam logic [ADDR_W-1:0] OFF_MASK =
    {{(ADDR_W-OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};

  function automatic logic [ADDR_W-1:0] line_align(
    input logic [ADDR_W-1:0] a
  );
    return a & ~OFF_MASK;
  endfunction
endpackage

// File: rtl/bmem_line_adapter_if.sv
// Burst-memory port: one command/beat channel out, one beat channel back.
// master = adapter side, slave = memory side.
interface bmem_line_adapter_if;
  import bmem_pkg::*;

  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [ADDR_W-1:0] bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/line_req_slot.sv
// One-deep line request holding register.
// A push in the same cycle as a pop refills the slot.
module line_req_slot
  import bmem_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  line_req_t req,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output line_req_t held
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      held <= '0;
    end else begin
      if (push) held <= req;
      if (push) full <= 1'b1;
      else if (pop) full <= 1'b0;
    end
  end

  assign empty = !full;
endmodule

// File: rtl/bmem_line_adapter.sv
// Turns 256-bit line read/write pulses into 4-beat 64-bit bursts.
// RESP doubles as a dispatch point so a pending request starts at once.
module bmem_line_adapter
  import bmem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_read,
  input  logic                req_write,
  input  logic [LINE_W-1:0]   req_wdata,
  output logic [LINE_W-1:0]   line_rdata,
  output logic                line_rvalid,
  output logic                line_wdone,
  output logic                arb_ready,
  output logic                proto_err,
  bmem_line_adapter_if.master mem
);
  adapter_state_t state, state_nxt;
  line_req_t cur, incoming, next_req, held;
  logic [1:0] cnt;
  logic [LINE_W-1:0] rline;
  logic new_vld, free, slot_full, slot_empty;
  logic take_slot, dispatch, slot_push, drop;
  logic beat_hit, beat_bad;

  assign new_vld = req_read | req_write;
  assign incoming = '{
    addr: line_align(req_addr),
    is_write: req_write,
    wdata: req_wdata
  };

  assign free = (state == IDLE) || (state == RESP);
  assign take_slot = free && slot_full;
  assign dispatch = free && (slot_full || new_vld);
  assign next_req = take_slot ? held : incoming;
  assign slot_push = new_vld && (take_slot || (!free && slot_empty));
  assign drop = new_vld && !free && slot_full;

  // any returning beat that is not a tagged beat for the open read is bad
  assign beat_hit = (state == RD_COLLECT) && mem.bmem_rvalid
                 && (mem.bmem_raddr == cur.addr);
  assign beat_bad = mem.bmem_rvalid && !beat_hit;

  assign arb_ready = mem.bmem_ready;

  line_req_slot u_slot (
    .clk   (clk),
    .rst   (rst),
    .push  (slot_push),
    .req   (incoming),
    .pop   (take_slot),
    .full  (slot_full),
    .empty (slot_empty),
    .held  (held)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cur <= '0;
      cnt <= '0;
      rline <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (dispatch) begin
        cur <= next_req;
        cnt <= '0;
      end else if (beat_hit || (state == WR_BURST && mem.bmem_ready)) begin
        cnt <= cnt + 2'd1;
      end
      if (beat_hit) rline[BEAT_W*cnt +: BEAT_W] <= mem.bmem_rdata;
      if ((req_read && req_write) || drop || beat_bad) proto_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    mem.bmem_read = 1'b0;
    mem.bmem_write = 1'b0;
    mem.bmem_addr = '0;
    mem.bmem_wdata = '0;
    line_rvalid = 1'b0;
    line_wdone = 1'b0;
    line_rdata = '0;
    unique case (state)
      IDLE, RESP: begin
        if (state == RESP) begin
          line_wdone = cur.is_write;
          line_rvalid = !cur.is_write;
          if (!cur.is_write) line_rdata = rline;
        end
        state_nxt = IDLE;
        if (dispatch) state_nxt = next_req.is_write ? WR_BURST : RD_ISSUE;
      end
      RD_ISSUE: begin
        mem.bmem_read = 1'b1;
        mem.bmem_addr = cur.addr;
        if (mem.bmem_ready) state_nxt = RD_COLLECT;
      end
      RD_COLLECT: begin
        if (beat_hit && cnt == 2'd3) state_nxt = RESP;
      end
      WR_BURST: begin
        mem.bmem_write = 1'b1;
        mem.bmem_addr = cur.addr;
        mem.bmem_wdata = cur.wdata[BEAT_W*cnt +: BEAT_W];
        if (mem.bmem_ready && cnt == 2'd3) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed bench: reactive burst-memory model, transaction-level
// expectation queue checked every cycle, plus literal pins per scenario.
module tb_bmem_line_adapter;
  import bmem_pkg::*;

  typedef struct {
    bit w;
    logic [31:0] a;
    logic [255:0] d;
  } txn_t;

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] req_addr;
  logic req_read, req_write;
  logic [255:0] req_wdata;
  logic [255:0] line_rdata;
  logic line_rvalid, line_wdone, arb_ready, proto_err;

  always #5 clk = ~clk;

  bmem_line_adapter_if mem();

  bmem_line_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .req_addr    (req_addr),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .line_rdata  (line_rdata),
    .line_rvalid (line_rvalid),
    .line_wdone  (line_wdone),
    .arb_ready   (arb_ready),
    .proto_err   (proto_err),
    .mem         (mem.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_of(input logic [31:0] a, input int i);
    logic [7:0] b;
    if (a == 32'h1ECEB000) begin
      b = 8'(17 * (i + 1));
      return {8{b}};
    end
    return {a, 32'(i) ^ 32'hC0DE0000};
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {beat_of(a, 3), beat_of(a, 2), beat_of(a, 1), beat_of(a, 0)};
  endfunction

  // memory model
  logic ready_r = 1'b1;
  logic rv_r = 1'b0;
  logic [31:0] raddr_r = '0;
  logic [63:0] rdata_r = '0;
  beat_t rq[$];
  int wb_n = 0;
  int stall_left = 0;
  int stall_at = 0;
  int stall_len = 0;
  bit bad_tag = 0;

  assign mem.bmem_ready = rst & ready_r;
  assign mem.bmem_rvalid = rst & rv_r;
  assign mem.bmem_raddr = raddr_r;
  assign mem.bmem_rdata = rdata_r;

  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rq.delete();
        wb_n = 0;
        stall_left = 0;
      end else begin
        if (mem.bmem_read && mem.bmem_ready) begin
          for (int i = 0; i < 4; i++) begin
            if (bad_tag && i == 2) begin
              e.a = 32'h1ECEB020;
              e.d = 64'hDEADBEEF_DEADBEEF;
              rq.push_back(e);
            end
            e.a = mem.bmem_addr;
            e.d = beat_of(mem.bmem_addr, i);
            rq.push_back(e);
          end
        end
        if (mem.bmem_write && mem.bmem_ready) begin
          wb_n = (wb_n + 1) % 4;
          if (stall_at != 0 && wb_n == stall_at) stall_left = stall_len;
        end
      end
      @(posedge clk);
      #1;
      ready_r = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (rst && rq.size() > 0) begin
        e = rq.pop_front();
        rv_r = 1'b1;
        raddr_r = e.a;
        rdata_r = e.d;
      end else begin
        rv_r = 1'b0;
      end
    end
  end

  // expectation queue and per-cycle compare
  txn_t req_q[$];
  txn_t ct;
  bit have;
  int head = 0;
  int wi = 0;
  int n_rd = 0;
  int n_wr = 0;
  int beat_n = 0;
  int rd_cmd_cyc = -1;
  int rvalid_cyc = -1;
  int wdone_cyc = -1;
  int last_beat_cyc = -1;
  int vis[4];
  int done_vis[4];
  logic [255:0] last_line = '0;
  logic [31:0] last_rd_addr = '0;
  logic [63:0] last_wbeat = '0;
  bit prev_read = 0;
  int req_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      head = req_q.size();
      wi = 0;
      prev_read = 0;
      vis = '{default: 0};
    end else begin
      have = head < req_q.size();
      if (have) ct = req_q[head];
      chk(!(mem.bmem_read && mem.bmem_write), "rd_wr_excl",
          {mem.bmem_read, mem.bmem_write}, 0);
      chk(arb_ready == mem.bmem_ready, "arb_ready", arb_ready, mem.bmem_ready);
      chk(!(line_rvalid && line_wdone), "resp_excl",
          {line_rvalid, line_wdone}, 0);
      if (!line_rvalid) chk(line_rdata == '0, "rdata_idle", line_rdata, 0);
      if (mem.bmem_rvalid) begin
        beat_n++;
        last_beat_cyc = cyc;
      end
      if (mem.bmem_read) begin
        if (!prev_read) rd_cmd_cyc = cyc;
        last_rd_addr = mem.bmem_addr;
        chk(have && !ct.w && mem.bmem_addr == ct.a, "rd_cmd",
            mem.bmem_addr, have ? ct.a : 0);
      end
      prev_read = mem.bmem_read;
      if (mem.bmem_write) begin
        chk(have && ct.w && wi < 4 && mem.bmem_addr == ct.a &&
            mem.bmem_wdata == ct.d[64*(wi&3) +: 64], "wr_beat",
            {mem.bmem_addr, mem.bmem_wdata},
            {ct.a, ct.d[64*(wi&3) +: 64]});
        if (wi < 4) vis[wi]++;
        if (mem.bmem_ready) begin
          last_wbeat = mem.bmem_wdata;
          wi++;
        end
      end
      if (line_rvalid) begin
        chk(have && !ct.w && line_rdata == line_of(ct.a), "line_rdata",
            line_rdata, have ? line_of(ct.a) : 0);
        last_line = line_rdata;
        rvalid_cyc = cyc;
        n_rd++;
        head++;
      end
      if (line_wdone) begin
        chk(have && ct.w && wi == 4, "wdone", wi, 4);
        done_vis = vis;
        vis = '{default: 0};
        wi = 0;
        wdone_cyc = cyc;
        n_wr++;
        head++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit rd, input bit wr,
                      input logic [31:0] a, input logic [255:0] d);
    req_addr = a;
    req_read = rd;
    req_write = wr;
    req_wdata = d;
    req_cyc = cyc;
    idle(1);
    req_read = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic expect_txn(input bit w, input logic [31:0] a,
                            input logic [255:0] d);
    txn_t t;
    t.w = w;
    t.a = a & 32'hFFFF_FFE0;
    t.d = d;
    req_q.push_back(t);
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (head != req_q.size() && n < maxc) begin
      idle(1);
      n++;
    end
    chk(head == req_q.size(), "timeout", 256'(head), 256'(req_q.size()));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);
  endtask

  logic [255:0] wline;
  int n0, w0, b0, k;

  initial begin
    rst = 1'b0;
    req_addr = '0;
    req_read = 1'b0;
    req_write = 1'b0;
    req_wdata = '0;
    idle(3);
    chk({line_rvalid, line_wdone, arb_ready, proto_err,
         mem.bmem_read, mem.bmem_write} == 6'b0, "reset_ctl",
        {line_rvalid, line_wdone, arb_ready, proto_err,
         mem.bmem_read, mem.bmem_write}, 0);
    chk(mem.bmem_addr == 0 && mem.bmem_wdata == 0 && line_rdata == 0,
        "reset_data", line_rdata, 0);
    rst = 1'b1;
    idle(2);

    // single read
    n0 = n_rd;
    expect_txn(0, 32'h1ECEB004, '0);
    send(1, 0, 32'h1ECEB004, '0);
    wait_done(40);
    chk(n_rd == n0 + 1, "t1_count", n_rd, n0 + 1);
    chk(last_rd_addr == 32'h1ECEB000, "t1_addr", last_rd_addr, 32'h1ECEB000);
    chk(last_line == {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}},
                      {4{16'h1111}}}, "t1_line", last_line, 0);
    chk(rd_cmd_cyc == req_cyc + 1, "t1_cmd_lat", rd_cmd_cyc, req_cyc + 1);
    chk(rvalid_cyc == last_beat_cyc + 1, "t1_rsp_lat",
        rvalid_cyc, last_beat_cyc + 1);
    chk(rvalid_cyc == req_cyc + 6, "t1_total_lat", rvalid_cyc, req_cyc + 6);
    idle(2);

    // single write with 3-cycle stall on beat B
    wline = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    w0 = n_wr;
    stall_at = 1;
    stall_len = 3;
    expect_txn(1, 32'h40, wline);
    send(0, 1, 32'h40, wline);
    wait_done(40);
    stall_at = 0;
    chk(n_wr == w0 + 1, "t2_count", n_wr, w0 + 1);
    chk(wdone_cyc == req_cyc + 8, "t2_done_lat", wdone_cyc, req_cyc + 8);
    chk(done_vis[1] == 4, "t2_b_hold", done_vis[1], 4);
    chk(done_vis[0] == 1 && done_vis[2] == 1 && done_vis[3] == 1,
        "t2_other_beats", {done_vis[0], done_vis[2], done_vis[3]}, 0);
    chk(last_wbeat == {4{16'hDDDD}}, "t2_last_beat", last_wbeat, 0);
    idle(2);

    // write then read during the burst
    wline = {8{32'h600D_F00D}};
    expect_txn(1, 32'h60, wline);
    send(0, 1, 32'h60, wline);
    idle(1);
    expect_txn(0, 32'h80, '0);
    send(1, 0, 32'h80, '0);
    wait_done(60);
    chk(rd_cmd_cyc == wdone_cyc + 1, "t3_b2b", rd_cmd_cyc, wdone_cyc + 1);
    chk(proto_err == 1'b0, "t3_perr", proto_err, 0);
    idle(2);

    // overflow: third request dropped
    n0 = n_rd;
    w0 = n_wr;
    wline = {4{64'h0123_4567_89AB_CDEF}};
    expect_txn(1, 32'hA0, wline);
    send(0, 1, 32'hA0, wline);
    expect_txn(0, 32'h1ECEB000, '0);
    send(1, 0, 32'h1ECEB000, '0);
    send(1, 0, 32'hC0, '0);
    wait_done(80);
    idle(10);
    chk(proto_err == 1'b1, "t4_perr", proto_err, 1);
    chk(n_wr == w0 + 1 && n_rd == n0 + 1, "t4_counts",
        {n_wr, n_rd}, {w0 + 1, n0 + 1});

    // simultaneous read and write: write wins
    do_reset();
    chk(proto_err == 1'b0, "t5_perr_clear", proto_err, 0);
    w0 = n_wr;
    wline = {16{16'h5A5A}};
    expect_txn(1, 32'h100, wline);
    send(1, 1, 32'h100, wline);
    wait_done(40);
    chk(proto_err == 1'b1, "t5_perr", proto_err, 1);
    chk(n_wr == w0 + 1, "t5_count", n_wr, w0 + 1);

    // bad tag beat
    do_reset();
    bad_tag = 1;
    expect_txn(0, 32'h1ECEB000, '0);
    send(1, 0, 32'h1ECEB000, '0);
    wait_done(40);
    bad_tag = 0;
    chk(proto_err == 1'b1, "t6_perr", proto_err, 1);
    chk(last_line == {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}},
                      {4{16'h1111}}}, "t6_line", last_line, 0);

    // reset after the second read beat
    do_reset();
    n0 = n_rd;
    b0 = beat_n;
    expect_txn(0, 32'h1ECEB000, '0);
    send(1, 0, 32'h1ECEB000, '0);
    k = 0;
    while (beat_n < b0 + 2 && k < 40) begin
      idle(1);
      k++;
    end
    chk(beat_n >= b0 + 2, "t7_beats", beat_n, b0 + 2);
    rst = 1'b0;
    #1;
    chk({line_rvalid, line_wdone, arb_ready, proto_err,
         mem.bmem_read, mem.bmem_write} == 6'b0, "t7_rst_ctl",
        {line_rvalid, line_wdone, arb_ready, proto_err,
         mem.bmem_read, mem.bmem_write}, 0);
    chk(mem.bmem_addr == 0 && mem.bmem_wdata == 0 && line_rdata == 0,
        "t7_rst_data", line_rdata, 0);
    idle(3);
    rst = 1'b1;
    idle(6);
    chk(n_rd == n0, "t7_no_rvalid", n_rd, n0);
    expect_txn(0, 32'h80, '0);
    send(1, 0, 32'h80, '0);
    wait_done(40);
    chk(n_rd == n0 + 1, "t7_fresh", n_rd, n0 + 1);
    chk(last_line == line_of(32'h80), "t7_line", last_line, line_of(32'h80));
    chk(proto_err == 1'b0, "t7_perr", proto_err, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
